// File: rtl/screen_sequencer.sv
// Steps TITLE -> GAME -> OVER behind a key-release hold and muxes the active screen onto one
// framebuffer write port. Optional OVER auto-exit timeout: define SCREEN_SEQ_TIMEOUT_EN.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 16
`endif

module screen_sequencer #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [25:0]                 key_status,
    input  logic                        title_fb_we,
    input  logic [`DISP_ADDR_WIDTH-1:0] title_fb_addr,
    input  logic [31:0]                 title_fb_wdata,
    input  logic                        title_done,
    input  logic                        game_fb_we,
    input  logic [`DISP_ADDR_WIDTH-1:0] game_fb_addr,
    input  logic [31:0]                 game_fb_wdata,
    input  logic                        game_done,
    input  logic                        over_fb_we,
    input  logic [`DISP_ADDR_WIDTH-1:0] over_fb_addr,
    input  logic [31:0]                 over_fb_wdata,
    input  logic                        over_done,
    output logic                        title_rst,
    output logic                        game_rst,
    output logic                        over_rst,
    output logic                        fb_we,
    output logic [`DISP_ADDR_WIDTH-1:0] fb_addr,
    output logic [31:0]                 fb_wdata,
    output logic [1:0]                  cur_screen,
    output logic                        screen_start
);

    typedef enum logic [1:0] {SCR_TITLE = 2'd0, SCR_GAME = 2'd1, SCR_OVER = 2'd2} screen_e;
    typedef enum logic {PH_REL = 1'b0, PH_RUN = 1'b1} phase_e;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    screen_e                       screen_r, screen_nxt_s;
    phase_e                        phase_r, phase_nxt_s;
    logic [HW-1:0]                 hold_cnt_r, hold_cnt_nxt_s;
    logic                          active_done_s, active_we_s;
    logic [`DISP_ADDR_WIDTH-1:0]   active_addr_s;
    logic [31:0]                   active_wdata_s;
    logic                          timeout_hit_s;
    logic                          title_rst_nxt_s, game_rst_nxt_s, over_rst_nxt_s;
    logic                          start_nxt_s, fb_we_nxt_s;

    function automatic screen_e next_screen(input screen_e cur);
        case (cur)
            SCR_TITLE: next_screen = SCR_GAME;
            SCR_GAME:  next_screen = SCR_OVER;
            SCR_OVER:  next_screen = SCR_TITLE;
            default:   next_screen = SCR_TITLE;
        endcase
    endfunction

`ifdef SCREEN_SEQ_TIMEOUT_EN
    localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYCLES - 1);
    logic [25:0] to_cnt_r;

    assign timeout_hit_s = (screen_r == SCR_OVER) && (phase_r == PH_RUN) && (to_cnt_r == TO_LAST);

    // OVER/RUN dwell counter; clears whenever OVER/RUN is left or not occupied
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r <= 26'd0;
        end else if ((screen_r == SCR_OVER) && (phase_r == PH_RUN) && !timeout_hit_s && !over_done) begin
            to_cnt_r <= to_cnt_r + 26'd1;
        end else begin
            to_cnt_r <= 26'd0;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Select the active screen's done and write port
    always_comb begin
        active_done_s  = 1'b0;
        active_we_s    = 1'b0;
        active_addr_s  = {`DISP_ADDR_WIDTH{1'b0}};
        active_wdata_s = 32'd0;
        case (screen_r)
            SCR_TITLE: begin
                active_done_s  = title_done;
                active_we_s    = title_fb_we;
                active_addr_s  = title_fb_addr;
                active_wdata_s = title_fb_wdata;
            end
            SCR_GAME: begin
                active_done_s  = game_done;
                active_we_s    = game_fb_we;
                active_addr_s  = game_fb_addr;
                active_wdata_s = game_fb_wdata;
            end
            SCR_OVER: begin
                active_done_s  = over_done | timeout_hit_s;
                active_we_s    = over_fb_we;
                active_addr_s  = over_fb_addr;
                active_wdata_s = over_fb_wdata;
            end
            default: begin
                active_done_s  = 1'b0;
                active_we_s    = 1'b0;
                active_addr_s  = {`DISP_ADDR_WIDTH{1'b0}};
                active_wdata_s = 32'd0;
            end
        endcase
    end

    // Next-state logic: saturating release-hold counter in REL, done-driven advance in RUN
    always_comb begin
        screen_nxt_s   = screen_r;
        phase_nxt_s    = phase_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (phase_r)
            PH_REL: begin
                if (key_status != 26'd0) begin
                    hold_cnt_nxt_s = {HW{1'b0}};
                end else if (hold_cnt_r >= HOLD_LAST) begin
                    phase_nxt_s    = PH_RUN;
                    hold_cnt_nxt_s = {HW{1'b0}};
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 1'b1;
                end
            end
            PH_RUN: begin
                hold_cnt_nxt_s = {HW{1'b0}};
                if (active_done_s) begin
                    screen_nxt_s = next_screen(screen_r);
                    phase_nxt_s  = PH_REL;
                end else begin
                    screen_nxt_s = screen_r;
                end
            end
            default: begin
                screen_nxt_s   = SCR_TITLE;
                phase_nxt_s    = PH_REL;
                hold_cnt_nxt_s = {HW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop
    always_comb begin
        title_rst_nxt_s = !((screen_nxt_s == SCR_TITLE) && (phase_nxt_s == PH_RUN));
        game_rst_nxt_s  = !((screen_nxt_s == SCR_GAME)  && (phase_nxt_s == PH_RUN));
        over_rst_nxt_s  = !((screen_nxt_s == SCR_OVER)  && (phase_nxt_s == PH_RUN));
        start_nxt_s     = (phase_r == PH_REL) && (phase_nxt_s == PH_RUN);
        fb_we_nxt_s     = active_we_s && (phase_r == PH_RUN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            screen_r     <= SCR_TITLE;
            phase_r      <= PH_REL;
            hold_cnt_r   <= {HW{1'b0}};
            title_rst    <= 1'b1;
            game_rst     <= 1'b1;
            over_rst     <= 1'b1;
            screen_start <= 1'b0;
            fb_we        <= 1'b0;
            fb_addr      <= {`DISP_ADDR_WIDTH{1'b0}};
            fb_wdata     <= 32'd0;
        end else begin
            screen_r     <= screen_nxt_s;
            phase_r      <= phase_nxt_s;
            hold_cnt_r   <= hold_cnt_nxt_s;
            title_rst    <= title_rst_nxt_s;
            game_rst     <= game_rst_nxt_s;
            over_rst     <= over_rst_nxt_s;
            screen_start <= start_nxt_s;
            fb_we        <= fb_we_nxt_s;
            fb_addr      <= active_addr_s;
            fb_wdata     <= active_wdata_s;
        end
    end

    assign cur_screen = screen_r;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: reset, release hold, forwarding, done filtering, timeout.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 16
`endif

module tb_screen_sequencer;

    localparam int AW = `DISP_ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic [25:0]   key_status;
    logic          title_fb_we, game_fb_we, over_fb_we;
    logic [AW-1:0] title_fb_addr, game_fb_addr, over_fb_addr;
    logic [31:0]   title_fb_wdata, game_fb_wdata, over_fb_wdata;
    logic          title_done, game_done, over_done;
    logic          title_rst, game_rst, over_rst, fb_we, screen_start;
    logic [AW-1:0] fb_addr;
    logic [31:0]   fb_wdata;
    logic [1:0]    cur_screen;
    logic          u1_title_rst, u1_game_rst, u1_over_rst, u1_fb_we, u1_screen_start;
    logic [AW-1:0] u1_fb_addr;
    logic [31:0]   u1_fb_wdata;
    logic [1:0]    u1_cur_screen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    screen_sequencer #(.HOLD_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .key_status(key_status),
        .title_fb_we(title_fb_we), .title_fb_addr(title_fb_addr), .title_fb_wdata(title_fb_wdata), .title_done(title_done),
        .game_fb_we(game_fb_we), .game_fb_addr(game_fb_addr), .game_fb_wdata(game_fb_wdata), .game_done(game_done),
        .over_fb_we(over_fb_we), .over_fb_addr(over_fb_addr), .over_fb_wdata(over_fb_wdata), .over_done(over_done),
        .title_rst(title_rst), .game_rst(game_rst), .over_rst(over_rst),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .cur_screen(cur_screen), .screen_start(screen_start)
    );

    // Second instance with a single-cycle hold, sharing all inputs
    screen_sequencer #(.HOLD_CYCLES(1), .TIMEOUT_CYCLES(10)) dut1 (
        .clk(clk), .reset(reset), .key_status(key_status),
        .title_fb_we(title_fb_we), .title_fb_addr(title_fb_addr), .title_fb_wdata(title_fb_wdata), .title_done(title_done),
        .game_fb_we(game_fb_we), .game_fb_addr(game_fb_addr), .game_fb_wdata(game_fb_wdata), .game_done(game_done),
        .over_fb_we(over_fb_we), .over_fb_addr(over_fb_addr), .over_fb_wdata(over_fb_wdata), .over_done(over_done),
        .title_rst(u1_title_rst), .game_rst(u1_game_rst), .over_rst(u1_over_rst),
        .fb_we(u1_fb_we), .fb_addr(u1_fb_addr), .fb_wdata(u1_fb_wdata),
        .cur_screen(u1_cur_screen), .screen_start(u1_screen_start)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        key_status = 26'd0;
        title_fb_we = 1'b0; game_fb_we = 1'b0; over_fb_we = 1'b0;
        title_fb_addr = '0; game_fb_addr = '0; over_fb_addr = '0;
        title_fb_wdata = 32'd0; game_fb_wdata = 32'd0; over_fb_wdata = 32'd0;
        title_done = 1'b0; game_done = 1'b0; over_done = 1'b0;
    endtask

    // Step until screen_start pulses, bounded by a cycle budget
    task automatic wait_start(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (screen_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: screen_start not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        step();
        checks++;
        if ({title_rst, game_rst, over_rst} !== 3'b111) begin
            errors++; $display("FAIL reset_rsts: got %b want 111", {title_rst, game_rst, over_rst});
        end
        checks++;
        if ({fb_we, fb_addr, fb_wdata} !== '0) begin
            errors++; $display("FAIL reset_fb: got we=%b addr=%h wdata=%h want 0", fb_we, fb_addr, fb_wdata);
        end
        checks++;
        if (cur_screen !== 2'd0 || screen_start !== 1'b0) begin
            errors++; $display("FAIL reset_screen: got cur=%0d start=%b want 0/0", cur_screen, screen_start);
        end
        reset = 1'b0;
    endtask

    task automatic test_release_hold;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 1) begin
                checks++;
                if (u1_screen_start !== 1'b1 || u1_title_rst !== 1'b0) begin
                    errors++; $display("FAIL hold1_start: got start=%b title_rst=%b want 1/0", u1_screen_start, u1_title_rst);
                end
            end
            if (i < 4) begin
                checks++;
                if (screen_start !== 1'b0 || title_rst !== 1'b1) begin
                    errors++; $display("FAIL hold_early c%0d: got start=%b title_rst=%b want 0/1", i, screen_start, title_rst);
                end
            end else begin
                checks++;
                if (screen_start !== 1'b1 || title_rst !== 1'b0 || cur_screen !== 2'd0) begin
                    errors++; $display("FAIL hold_start: got start=%b title_rst=%b cur=%0d want 1/0/0", screen_start, title_rst, cur_screen);
                end
            end
        end
        step();
        checks++;
        if (screen_start !== 1'b0 || title_rst !== 1'b0) begin
            errors++; $display("FAIL hold_pulse: got start=%b title_rst=%b want 0/0", screen_start, title_rst);
        end
    endtask

    task automatic test_key_bounce;
        reset = 1'b1;
        step();
        reset = 1'b0;
        title_fb_we = 1'b1;
        title_fb_addr = AW'(3);
        step();
        key_status = 26'h1;
        step();
        key_status = 26'd0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (screen_start !== ((i == 4) ? 1'b1 : 1'b0) || fb_we !== 1'b0) begin
                errors++; $display("FAIL bounce c%0d: got start=%b fb_we=%b want %b/0", i, screen_start, fb_we, (i == 4));
            end
        end
        step();
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== AW'(3)) begin
            errors++; $display("FAIL bounce_write: got we=%b addr=%h want 1/3", fb_we, fb_addr);
        end
    endtask

    task automatic test_done_with_write;
        title_fb_we = 1'b1;
        title_fb_addr = AW'(5);
        title_fb_wdata = 32'hABCD;
        title_done = 1'b1;
        step();
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== AW'(5) || fb_wdata !== 32'hABCD) begin
            errors++; $display("FAIL done_write_fb: got we=%b addr=%h wdata=%h want 1/5/abcd", fb_we, fb_addr, fb_wdata);
        end
        checks++;
        if (cur_screen !== 2'd1 || title_rst !== 1'b1 || game_rst !== 1'b1) begin
            errors++; $display("FAIL done_write_state: got cur=%0d title_rst=%b game_rst=%b want 1/1/1", cur_screen, title_rst, game_rst);
        end
        clear_inputs();
        game_fb_we = 1'b1;
        game_done = 1'b1;
        step();
        checks++;
        if (cur_screen !== 2'd1 || fb_we !== 1'b0) begin
            errors++; $display("FAIL rel_ignore: got cur=%0d fb_we=%b want 1/0", cur_screen, fb_we);
        end
        clear_inputs();
        wait_start("game_start", 8);
    endtask

    task automatic test_ignore_done;
        over_done = 1'b1;
        title_done = 1'b1;
        game_fb_we = 1'b1; game_fb_addr = AW'(7); game_fb_wdata = 32'h1234;
        title_fb_we = 1'b1; title_fb_addr = AW'(9); title_fb_wdata = 32'h9999;
        step();
        checks++;
        if (cur_screen !== 2'd1 || game_rst !== 1'b0) begin
            errors++; $display("FAIL inactive_done: got cur=%0d game_rst=%b want 1/0", cur_screen, game_rst);
        end
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== AW'(7) || fb_wdata !== 32'h1234) begin
            errors++; $display("FAIL game_mux: got we=%b addr=%h wdata=%h want 1/7/1234", fb_we, fb_addr, fb_wdata);
        end
        clear_inputs();
        game_done = 1'b1;
        step();
        game_done = 1'b0;
        checks++;
        if (cur_screen !== 2'd2 || game_rst !== 1'b1 || over_rst !== 1'b1) begin
            errors++; $display("FAIL game_done: got cur=%0d game_rst=%b over_rst=%b want 2/1/1", cur_screen, game_rst, over_rst);
        end
    endtask

    task automatic test_timeout;
        logic [1:0] exp_final;
`ifdef SCREEN_SEQ_TIMEOUT_EN
        exp_final = 2'd0;
`else
        exp_final = 2'd2;
`endif
        wait_start("over_start", 8);
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (cur_screen !== ((i == 10) ? exp_final : 2'd2)) begin
                errors++; $display("FAIL timeout c%0d: got cur=%0d want %0d", i, cur_screen, (i == 10) ? exp_final : 2'd2);
            end
        end
        if (exp_final == 2'd2) begin
            over_done = 1'b1;
            step();
            over_done = 1'b0;
            checks++;
            if (cur_screen !== 2'd0) begin
                errors++; $display("FAIL over_done: got cur=%0d want 0", cur_screen);
            end
        end
    endtask

    task automatic test_reset_priority;
        wait_start("title_restart", 8);
        title_done = 1'b1;
        step();
        title_done = 1'b0;
        wait_start("game_restart", 8);
        game_done = 1'b1;
        game_fb_we = 1'b1; game_fb_addr = AW'(11); game_fb_wdata = 32'h55;
        reset = 1'b1;
        step();
        checks++;
        if (cur_screen !== 2'd0 || {title_rst, game_rst, over_rst} !== 3'b111 || screen_start !== 1'b0) begin
            errors++; $display("FAIL rst_prio_state: got cur=%0d rsts=%b start=%b want 0/111/0", cur_screen, {title_rst, game_rst, over_rst}, screen_start);
        end
        checks++;
        if ({fb_we, fb_addr, fb_wdata} !== '0) begin
            errors++; $display("FAIL rst_prio_fb: got we=%b addr=%h wdata=%h want 0", fb_we, fb_addr, fb_wdata);
        end
        reset = 1'b0;
        clear_inputs();
        step();
        checks++;
        if (title_rst !== 1'b1 || screen_start !== 1'b0 || cur_screen !== 2'd0) begin
            errors++; $display("FAIL rst_prio_rel: got title_rst=%b start=%b cur=%0d want 1/0/0", title_rst, screen_start, cur_screen);
        end
    endtask

    initial begin
        test_reset();
        test_release_hold();
        test_key_bounce();
        test_done_with_write();
        test_ignore_done();
        test_timeout();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES SHALL default to 4; it is the number of consecutive all-keys-released cycles required before a screen starts.
REQ-002 Parameter TIMEOUT_CYCLES SHALL default to 50_000_000; it is the OVER auto-exit delay (REQ-024), 26-bit range.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 key_status  in  26  one bit per key, 1 = pressed.
REQ-006 <s>_fb_we / <s>_fb_addr / <s>_fb_wdata  in  1 / `DISP_ADDR_WIDTH / 32  framebuffer write port of screen <s>, for <s> in {title, game, over}.
REQ-007 <s>_done  in  1  screen <s> exit pulse.
REQ-008 <s>_rst  out  1  active-high synchronous hold-in-reset to screen <s>.
REQ-009 fb_we / fb_addr / fb_wdata  out  1 / `DISP_ADDR_WIDTH / 32  shared framebuffer write port.
REQ-010 cur_screen  out  2  active screen: 0 TITLE, 1 GAME, 2 OVER; 3 is never driven.
REQ-011 screen_start  out  1  one-cycle pulse when a screen enters RUN.

Function
REQ-012 State SHALL be {screen, phase}, with screen in {TITLE, GAME, OVER} and phase in {REL, RUN}.
REQ-013 In REL, a hold counter SHALL increment while key_status == 0 and clear to 0 on any nonzero key_status cycle.
REQ-014 When the hold counter reaches HOLD_CYCLES-1 with key_status == 0, phase SHALL go to RUN next cycle, the counter SHALL clear, and screen_start SHALL pulse high for that cycle.
REQ-015 <s>_rst SHALL be 0 only for the active screen while in RUN, and 1 otherwise, including for the active screen in REL.
REQ-016 In RUN, the active screen's done SHALL advance the screen TITLE->GAME->OVER->TITLE with phase REL on the next cycle.
REQ-017 done inputs of inactive screens, and any done during REL, SHALL be ignored.
REQ-018 fb outputs SHALL be registered with a latency of 1 cycle: fb_we(t+1) = active <s>_fb_we(t) AND phase(t) == RUN; fb_addr and fb_wdata follow the active screen unconditionally.
REQ-019 fb_we SHALL be 0 on the cycle following any cycle in REL, so no write escapes from a screen held in reset.
REQ-020 When done and a write arrive in the same cycle, the write SHALL be forwarded (REQ-018) and the transition SHALL still occur.
REQ-021 The hold counter SHALL saturate and never wrap; HOLD_CYCLES = 1 SHALL give REL->RUN on the first released cycle.

Reset
REQ-022 On reset = 1, screen SHALL be TITLE, phase REL and counters 0, with outputs title_rst = game_rst = over_rst = 1, fb_we = 0, fb_addr = 0, fb_wdata = 0, cur_screen = 0 and screen_start = 0.
REQ-023 Reset asserted mid-RUN SHALL take priority over done, keys and timeout in the same cycle.

Configuration
REQ-024 With SCREEN_SEQ_TIMEOUT_EN defined, a 26-bit counter SHALL count cycles in OVER/RUN; reaching TIMEOUT_CYCLES-1 SHALL act as over_done, and the counter SHALL clear on leaving OVER/RUN or on reset.
REQ-025 Without SCREEN_SEQ_TIMEOUT_EN, no timeout counter SHALL exist and OVER SHALL exit only on over_done.

Verification
REQ-026 Reset, keys 0 for 4 cycles -> screen_start at cycle 4, title_rst = 0, cur_screen = 0.
REQ-027 In REL, key_status = 26'h1 on cycle 2 then 0 -> RUN entry delayed to 4 clean cycles after release; fb_we stays 0 throughout.
REQ-028 TITLE RUN, title_fb_we = 1, addr = 5, wdata = 32'hABCD, plus title_done the same cycle -> next cycle fb_we = 1, fb_addr = 5, fb_wdata = 32'hABCD, cur_screen = 1, phase REL, title_rst = 1.
REQ-029 GAME RUN, pulse over_done and title_done -> no transition; game_done -> cur_screen = 2.
REQ-030 With SCREEN_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 10, OVER RUN with no done -> cur_screen = 0 exactly 10 cycles after entering RUN; without the macro, cur_screen stays 2.
REQ-031 Reset pulse during GAME RUN with game_done high -> state TITLE/REL and all REQ-022 values the next cycle.
